p2s_rr_scheduler: RTL and testbench
===================================

Name: p2s_rr_scheduler

Overview:
Shares one parallel-to-serial shift datapath between NUM_REQ requesters. A round-robin arbiter accepts one DATA_W-bit word per grant, and the word is shifted out LSB-first. Frames go out back-to-back with no idle gap when requests are pending. The block sits between multiple parallel producers and a single serial link, and tags each frame with its source id.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 4, bits per frame (2..32)
ID_W, $clog2(NUM_REQ), width of src_id_o

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-low reset
req_i  in  NUM_REQ  per-requester request level; held until granted
data_i  in  NUM_REQ*DATA_W  requester k word at [k*DATA_W +: DATA_W]; must be stable while req_i[k]=1
mask_i  in  NUM_REQ  1 = requester k is eligible; 0 = ignored
gnt_o  out  NUM_REQ  one-hot, combinational; word captured at the clock edge ending this cycle
serial_o  out  1  current serial bit
valid_o  out  1  serial_o carries frame data
last_o  out  1  final bit (bit DATA_W-1) of the current frame
src_id_o  out  ID_W  index of the requester owning the current frame
busy_o  out  1  frame in progress (equals valid_o)

Behaviour:
- Reset (reset=0 at posedge):
  - State goes to IDLE; shift reg, bit_cnt and src_id_o go to 0; RR pointer goes to 0 (requester 0 highest priority).
  - serial_o, valid_o, last_o and busy_o are 0.
  - gnt_o is forced to all-zero in any cycle where reset=0.
- States:
  - IDLE: no frame.
  - SHIFT: frame active, bit_cnt 0..DATA_W-1.
- Accept window: the cycle is in IDLE, or in SHIFT with bit_cnt==DATA_W-1.
- Eligibility: eligible = req_i & mask_i.
- In an accept window with eligible!=0:
  - gnt_o = the first eligible index searching from ptr upward, wrapping modulo NUM_REQ.
  - At the edge: shift reg <= selected word; src_id <= index; bit_cnt <= 0; ptr <= (index+1) mod NUM_REQ; state <= SHIFT.
- In an accept window with eligible==0: gnt_o=0. From SHIFT the block goes to IDLE; IDLE stays IDLE.
- Outside the accept window, gnt_o=0.
- Latency: a grant in cycle t puts bit 0 on serial_o in cycle t+1. Bit k appears in cycle t+1+k.
- In SHIFT: serial_o = shreg[0]; the shift reg shifts right by 1 and bit_cnt increments each cycle.
- last_o = valid_o & (bit_cnt==DATA_W-1).
- Back-to-back frames: a grant in the last-bit cycle makes the next frame's bit 0 follow immediately; valid_o stays high.
- In IDLE: serial_o=0, valid_o=0, src_id_o holds its last value.
- Requester side: ownership of the word passes at the grant edge. Dropping req_i[k] before a grant simply withdraws the request; no error is flagged.
- mask_i changes take effect in the same cycle and never disturb a frame in progress.
- Reset mid-frame: the frame is abandoned. In the cycle after the reset edge valid_o=0. Arbitration restarts from ptr=0 in the first cycle with reset=1.
- Widths:
  - bit_cnt is $clog2(DATA_W) bits and never exceeds DATA_W-1.
  - ptr wraps explicitly modulo NUM_REQ, which is also correct for non-power-of-two NUM_REQ.

Decomposition:
- Package p2s_sched_pkg:
  - state enum {ST_IDLE, ST_SHIFT}.
  - Default NUM_REQ/DATA_W constants.
  - Function for the modulo-NUM_REQ pointer increment.
- Sub-module p2s_rr_arbiter holds the combinational round-robin pick. Inputs: eligible, ptr, enable. Outputs: one-hot gnt, binary index, any.
- The top module owns the FSM, the shift reg, bit_cnt and the ptr register.

Test Plan:
1. Single request. NUM_REQ=4, DATA_W=4; req_i=0001, data0=4'b1011. Required: gnt_o=0001 in the same cycle. Next 4 cycles: serial_o 1,1,0,1, valid_o=1, src_id_o=0, last_o only on the 4th. Then valid_o=0.
2. All four requesting continuously, data k = k+1. Required: grant order 0,1,2,3,0,1. valid_o stays 1 for 24 consecutive cycles. Each gnt_o pulse coincides with last_o, except the first grant, which comes from IDLE.
3. Fairness. After a grant to requester 2, assert req_i=1010. Required: requester 3 is granted before requester 1.
4. Masking. mask_i=1101, req_i=0010. Required: gnt_o=0 and valid_o=0 for 10 cycles. Then set mask_i=1111: gnt_o=0010 that cycle, and a frame with src_id_o=1 follows.
5. Reset mid-frame. Drive reset=0 during bit 2 of a frame from requester 3, with req0 held. Required: the cycle after the reset edge shows valid_o=0 and serial_o=0. In the first cycle with reset=1, gnt_o=0001 (ptr back at 0).
6. Gap handling. A single request is granted, then req_i=0 through last_o, then req_i=0100 two cycles later. Required: valid_o=0 for exactly 2 cycles between frames, and the new frame starts the cycle after its grant.

Source files
------------

// File: rtl/p2s_sched_pkg.sv
// Shared types and helpers for the round-robin parallel-to-serial scheduler.
package p2s_sched_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 4;

    // Wide enough for any requester index up to 16 requesters.
    localparam int PTR_MAX_W = 4;

    // Wraps explicitly so non-power-of-two requester counts stay in range.
    function automatic logic [PTR_MAX_W-1:0] rr_inc(input logic [PTR_MAX_W-1:0] idx,
                                                    input int                    n);
        if (int'(idx) >= n - 1) return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/p2s_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or above ptr, wrapping.
module p2s_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        int          cand;
        logic [ID_W-1:0] cand_idx;
        gnt      = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = ID_W'(cand);
            if (enable && !any && eligible[cand_idx]) begin
                any           = 1'b1;
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/p2s_rr_scheduler.sv
// Round-robin scheduler sharing one LSB-first serializer between NUM_REQ producers.
//   state    | meaning
//   ST_IDLE  | no frame on the link; any eligible request is granted immediately
//   ST_SHIFT | frame active, bit_cnt = 0..DATA_W-1; last bit doubles as accept slot
module p2s_rr_scheduler
    import p2s_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    input  logic [NUM_REQ-1:0]        mask_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic                      serial_o,
    output logic                      valid_o,
    output logic                      last_o,
    output logic [ID_W-1:0]           src_id_o,
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(DATA_W);

    state_e              state;
    logic [DATA_W-1:0]   shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     src_id;

    logic                last_bit;
    logic                accept;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_any;
    logic [DATA_W-1:0]   words [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            words[k] = data_i[k*DATA_W +: DATA_W];
        end
    end

    assign last_bit = (state == ST_SHIFT) && (bit_cnt == CNT_W'(DATA_W - 1));
    // Gating with reset keeps grants off while the block is held in reset.
    assign accept   = reset && ((state == ST_IDLE) || last_bit);
    assign eligible = req_i & mask_i;

    p2s_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .enable   (accept),
        .gnt      (arb_gnt),
        .idx      (arb_idx),
        .any      (arb_any)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            src_id  <= '0;
            ptr     <= '0;
        end else if (arb_any) begin
            state   <= ST_SHIFT;
            shreg   <= words[arb_idx];
            src_id  <= arb_idx;
            bit_cnt <= '0;
            ptr     <= ID_W'(rr_inc(PTR_MAX_W'(arb_idx), NUM_REQ));
        end else if (state == ST_SHIFT) begin
            shreg <= shreg >> 1;
            if (last_bit) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign gnt_o    = arb_gnt;
    assign valid_o  = (state == ST_SHIFT);
    assign busy_o   = valid_o;
    assign serial_o = valid_o & shreg[0];
    assign last_o   = last_bit;
    assign src_id_o = src_id;

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Scoreboard bench: stimulus pushes expected serial bits, a negedge monitor pops on valid_o.
module tb_p2s_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 4;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic            ser;
        logic            lst;
        logic [ID_W-1:0] id;
    } exp_t;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0]        mask_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic                      serial_o;
    logic                      valid_o;
    logic                      last_o;
    logic [ID_W-1:0]           src_id_o;
    logic                      busy_o;

    logic [DATA_W-1:0] d [NUM_REQ];
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_err    = 0;

    p2s_rr_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_i),
        .data_i   (data_i),
        .mask_i   (mask_i),
        .gnt_o    (gnt_o),
        .serial_o (serial_o),
        .valid_o  (valid_o),
        .last_o   (last_o),
        .src_id_o (src_id_o),
        .busy_o   (busy_o)
    );

    always_comb begin
        data_i = '0;
        for (int k = 0; k < NUM_REQ; k++) data_i[k*DATA_W +: DATA_W] = d[k];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int id);
        exp_t e;
        for (int b = 0; b < DATA_W; b++) begin
            e.ser = d[id][b];
            e.lst = (b == DATA_W - 1);
            e.id  = ID_W'(id);
            exp_q.push_back(e);
        end
    endtask

    // One cycle: sample at negedge, check grant/valid, enqueue a frame on grant.
    task automatic cyc(input string name, input logic [NUM_REQ-1:0] eg, input logic ev);
        @(negedge clk);
        check({name, "_gnt"}, gnt_o, eg);
        check({name, "_valid"}, valid_o, ev);
        if (!ev) check({name, "_serial_idle"}, serial_o, 1'b0);
        if (eg != '0) begin
            if (ev) check({name, "_gnt_on_last"}, last_o, 1'b1);
            for (int k = 0; k < NUM_REQ; k++) if (eg[k]) push_frame(k);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        check("busy_eq_valid", busy_o, valid_o);
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bit", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("serial_bit", {serial_o, last_o, src_id_o}, {e.ser, e.lst, e.id});
            end
        end
    end

    initial begin
        reset  = 1'b0;
        req_i  = '1;
        mask_i = '1;
        d[0] = 4'b1011; d[1] = 4'b1001; d[2] = 4'b0101; d[3] = 4'b0110;

        // Reset state: grants forced off even with every request up.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_gnt", gnt_o, '0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_serial", serial_o, 1'b0);
        check("rst_last", last_o, 1'b0);
        check("rst_src", src_id_o, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_i = '0;
        cyc("idle", '0, 1'b0);

        // Single request.
        req_i = 4'b0001;
        cyc("t1_grant", 4'b0001, 1'b0);
        req_i = '0;
        repeat (4) cyc("t1_frame", '0, 1'b1);
        cyc("t1_end", '0, 1'b0);

        // Restart from ptr=0, then all four continuously requesting.
        reset = 1'b0;
        cyc("t2_rst", '0, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) d[k] = DATA_W'(k + 1);
        req_i = 4'b1111;
        for (int c = 0; c < 26; c++) begin
            logic [NUM_REQ-1:0] eg;
            eg = '0;
            if ((c % 4 == 0) && c <= 20) eg[(c / 4) % 4] = 1'b1;
            cyc("t2", eg, (c >= 1 && c <= 24));
            if (c == 20) req_i = '0;
        end

        // Fairness: after requester 2, requester 3 precedes requester 1.
        d[1] = 4'b1001; d[2] = 4'b0101; d[3] = 4'b0110;
        req_i = 4'b0100;
        cyc("t3_g2", 4'b0100, 1'b0);
        req_i = 4'b1010;
        repeat (3) cyc("t3_f2", '0, 1'b1);
        cyc("t3_g3", 4'b1000, 1'b1);
        req_i = 4'b0010;
        repeat (3) cyc("t3_f3", '0, 1'b1);
        cyc("t3_g1", 4'b0010, 1'b1);
        req_i = '0;
        repeat (4) cyc("t3_f1", '0, 1'b1);
        cyc("t3_end", '0, 1'b0);

        // Masking.
        mask_i = 4'b1101;
        req_i  = 4'b0010;
        repeat (10) cyc("t4_masked", '0, 1'b0);
        mask_i = 4'b1111;
        cyc("t4_unmask", 4'b0010, 1'b0);
        req_i = '0;
        repeat (4) cyc("t4_frame", '0, 1'b1);
        cyc("t4_end", '0, 1'b0);

        // Reset during bit 2 of a frame from requester 3, req0 held.
        req_i = 4'b1000;
        cyc("t5_g3", 4'b1000, 1'b0);
        req_i = 4'b1001;
        repeat (2) cyc("t5_b01", '0, 1'b1);
        reset = 1'b0;
        cyc("t5_b2_rst", '0, 1'b1);
        reset = 1'b1;
        void'(exp_q.pop_back());
        cyc("t5_after_rst", 4'b0001, 1'b0);
        req_i = '0;
        repeat (4) cyc("t5_frame0", '0, 1'b1);
        cyc("t5_end", '0, 1'b0);

        // Gap handling: exactly two idle cycles between frames.
        req_i = 4'b0100;
        cyc("t6_g2a", 4'b0100, 1'b0);
        req_i = '0;
        repeat (4) cyc("t6_fa", '0, 1'b1);
        cyc("t6_gap1", '0, 1'b0);
        req_i = 4'b0100;
        cyc("t6_g2b", 4'b0100, 1'b0);
        req_i = '0;
        repeat (4) cyc("t6_fb", '0, 1'b1);
        cyc("t6_end", '0, 1'b0);

        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
